// File: rtl/piece_bag_gen.sv
// 7-bag piece randomiser: a Galois LFSR picks candidates, a dealt-mask keeps each group
// of NUM_KINDS pieces a permutation, and a small FIFO holds the head plus preview slots.
module piece_bag_gen #(
    parameter int                LFSR_W        = 16,
    parameter logic [LFSR_W-1:0] TAPS          = 16'hB400,
    parameter int                NUM_KINDS     = 7,
    parameter int                PREVIEW_DEPTH = 3,
    localparam int               KW            = 3,
    localparam int               D             = PREVIEW_DEPTH + 1,
    localparam int               CW            = $clog2(D + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [LFSR_W-1:0]         seed,
    input  logic                      flush,
    input  logic                      take,
    output logic                      valid,
    output logic [KW-1:0]             piece,
    output logic [KW*PREVIEW_DEPTH-1:0] preview,
    output logic [CW-1:0]             count
);

    localparam logic [KW:0]  NK    = (KW+1)'(NUM_KINDS);
    localparam logic [CW-1:0] DEPTH = CW'(D);

    logic [LFSR_W-1:0]    lfsr;
    logic [NUM_KINDS-1:0] bag;
    logic [KW-1:0]        fifo [D];

    logic [LFSR_W-1:0]    lfsr_next;
    logic [LFSR_W-1:0]    cand_full;
    logic [KW-1:0]        cand;
    logic [KW-1:0]        pick;
    logic [KW:0]          idx;
    logic                 found;
    logic                 pop;
    logic                 push;
    logic [NUM_KINDS-1:0] bag_set;
    logic [NUM_KINDS-1:0] bag_n;
    logic [KW-1:0]        fifo_n [D];
    logic [CW-1:0]        cnt_after;
    logic [CW-1:0]        cnt_n;

    assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    assign cand_full = lfsr % LFSR_W'(NUM_KINDS);
    assign cand      = cand_full[KW-1:0];

    // First free kind at or after the candidate, wrapping; the mask is never all-ones.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int j = 0; j < NUM_KINDS; j++) begin
            idx = {1'b0, cand} + (KW+1)'(j);
            if (idx >= NK) idx = idx - NK;
            if (!found && !bag[idx[KW-1:0]]) begin
                pick  = idx[KW-1:0];
                found = 1'b1;
            end
        end
    end

    assign valid = (count != '0);
    assign pop   = take && valid && !flush;
    assign push  = !flush && ((count < DEPTH) || pop);

    assign bag_set = bag | (NUM_KINDS'(1) << pick);

    always_comb begin
        fifo_n    = fifo;
        cnt_after = count;
        cnt_n     = count;
        bag_n     = bag;
        if (flush) begin
            for (int i = 0; i < D; i++) fifo_n[i] = '0;
            cnt_n = '0;
            bag_n = '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < D - 1; i++) fifo_n[i] = fifo[i+1];
                fifo_n[D-1] = '0;
                cnt_after   = count - CW'(1);
            end
            cnt_n = cnt_after;
            if (push) begin
                for (int i = 0; i < D; i++)
                    if (CW'(i) == cnt_after) fifo_n[i] = pick;
                cnt_n = cnt_after + CW'(1);
                bag_n = (&bag_set) ? '0 : bag_set;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr  <= (seed == '0) ? LFSR_W'(1) : seed;
            bag   <= '0;
            count <= '0;
            for (int i = 0; i < D; i++) fifo[i] <= '0;
        end else begin
            lfsr  <= lfsr_next;
            bag   <= bag_n;
            count <= cnt_n;
            for (int i = 0; i < D; i++) fifo[i] <= fifo_n[i];
        end
    end

    // Unfilled slots are held at zero, so head and preview read straight from the FIFO.
    assign piece = fifo[0];
    for (genvar k = 0; k < PREVIEW_DEPTH; k++) begin : g_preview
        assign preview[KW*k +: KW] = fifo[k+1];
    end

endmodule
